display_scan_ctrl: RTL
======================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed hex digits (legal 2..8).
REQ-002 SHALL have parameter DWELL_CYCLES, default 100000, clock cycles each digit anode is driven (legal >= 2).
REQ-003 SHALL have parameter GUARD_CYCLES, default 16, all-anodes-off cycles between digits to suppress ghosting (legal >= 0).
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port value_i  input  4*NUM_DIGITS  hex value; digit k is value_i[4k+3:4k], digit 0 rightmost.
REQ-007 SHALL have port load_i  input  1  one-cycle strobe requesting value_i be displayed.
REQ-008 SHALL have port digit_en_i  input  NUM_DIGITS  per-digit enable; 0 keeps that digit dark during its slot.
REQ-009 SHALL have port blank_i  input  1  level; 1 turns the whole display off.
REQ-010 SHALL have port nibble_o  output  4  nibble for the shared 7-segment decoder, bit 3 = d3.
REQ-011 SHALL have port an_o  output  NUM_DIGITS  anode enables, active-low, at most one bit low.
REQ-012 SHALL have port frame_o  output  1  one-cycle pulse at each frame boundary.
REQ-013 SHALL have port load_pending_o  output  1  a load has been captured but not yet applied.

Function
REQ-014 SHALL implement states OFF, DRIVE, GUARD, plus digit index idx (0..NUM_DIGITS-1) and a shared cycle timer.
REQ-015 SHALL keep a shadow register (displayed value) and a pending register with pending flag.
REQ-016 SHALL, on load_i, copy value_i into pending and set the pending flag; a later load_i before apply overwrites pending.
REQ-017 SHALL apply pending into shadow and clear the flag only at a frame boundary: OFF->DRIVE transition or GUARD exit with idx = NUM_DIGITS-1.
REQ-018 SHALL, when load_i coincides with a frame boundary, write value_i directly to shadow and leave the flag clear.
REQ-019 SHALL, in OFF, drive an_o all ones; if blank_i=0, move to DRIVE next cycle with idx=0, timer=0.
REQ-020 SHALL, in DRIVE, drive nibble_o = shadow[4*idx+3:4*idx] and an_o[idx]=0 if digit_en_i[idx]=1, else all ones; all other bits 1.
REQ-021 SHALL, in DRIVE, increment timer; at timer = DWELL_CYCLES-1 reset timer to 0 and go to GUARD (or directly to next digit's DRIVE if GUARD_CYCLES=0).
REQ-022 SHALL, in GUARD, drive an_o all ones and hold nibble_o; at timer = GUARD_CYCLES-1 advance idx (wrap NUM_DIGITS-1 -> 0), timer=0, enter DRIVE.
REQ-023 SHALL assert frame_o for exactly the cycle in which idx wraps to 0; also on the OFF->DRIVE cycle.
REQ-024 SHALL, when blank_i=1 in any state, enter OFF next cycle with idx=0, timer=0; an_o all ones from that cycle on; pending unaffected.
REQ-025 SHALL register an_o and nibble_o so they change only on clk_i edges and never glitch.
REQ-026 SHALL never drive more than one an_o bit low in any cycle, including on transitions.

Reset
REQ-027 SHALL, while rst_i=1, set state=OFF, idx=0, timer=0, shadow=0, pending=0, flag=0, an_o all ones, nibble_o=0, frame_o=0, load_pending_o=0.
REQ-028 SHALL, with rst_i deasserted and blank_i=0, enter DRIVE on digit 0 the following cycle with frame_o=1.
REQ-029 SHALL, on rst_i mid-frame, abandon the current slot and discard any pending load.

Verification (NUM_DIGITS=4, DWELL_CYCLES=4, GUARD_CYCLES=1)
REQ-030 Reset release, blank_i=0, digit_en_i=4'b1111, shadow 0 -> an_o 1110 for 4 cycles, 1111 for 1, 1101 for 4, ...; frame_o every 20 cycles; nibble_o=0.
REQ-031 load_i with value_i=16'h1A2F mid-frame -> load_pending_o=1 until next frame_o cycle; thereafter nibble_o F,2,A,1 in slots 0..3.
REQ-032 load_i with 16'hBEEF exactly on a frame_o cycle -> shadow=16'hBEEF that cycle, load_pending_o stays 0, next slot shows F.
REQ-033 digit_en_i=4'b0101 -> an_o low only during slots 0 and 2; slots 1 and 3 all ones for full dwell; timing unchanged.
REQ-034 blank_i pulsed high 3 cycles during slot 2 -> an_o all ones from next cycle; on release restart at digit 0 with frame_o=1.
REQ-035 Every cycle of all scenarios -> popcount(~an_o) <= 1 (assertion).

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Multiplexed hex display scanner: cycles through the digits with a dwell and an
// all-off guard gap, and applies display updates only at frame boundaries.
module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    load_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic                    blank_i,
    output logic [3:0]              nibble_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o,
    output logic                    load_pending_o
);

    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int TMAX = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam int VW   = 4 * NUM_DIGITS;

    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] GUARD_LAST = TW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DRIVE,
        ST_GUARD
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [VW-1:0]           shadow_q, shadow_d;
    logic [VW-1:0]           pending_q, pending_d;
    logic                    pend_flag_q, pend_flag_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [3:0]              nibble_q, nibble_d;
    logic                    frame_pulse;
    logic                    last_digit;
    logic [IW-1:0]           idx_adv;
    logic [NUM_DIGITS-1:0]   digit_sel;

    assign last_digit = (idx_q == IDX_LAST);
    assign idx_adv    = last_digit ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;
        frame_pulse = 1'b0;

        case (state_q)
            ST_OFF: begin
                state_d     = ST_DRIVE;
                idx_d       = '0;
                timer_d     = '0;
                frame_pulse = 1'b1;
            end
            ST_DRIVE: begin
                if (timer_q == DWELL_LAST) begin
                    timer_d = '0;
                    if (GUARD_CYCLES == 0) begin
                        idx_d       = idx_adv;
                        frame_pulse = last_digit;
                    end else begin
                        state_d = ST_GUARD;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_GUARD: begin
                if (timer_q == GUARD_LAST) begin
                    timer_d     = '0;
                    state_d     = ST_DRIVE;
                    idx_d       = idx_adv;
                    frame_pulse = last_digit;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
                idx_d   = '0;
                timer_d = '0;
            end
        endcase

        // Blanking overrides any transition, including a frame boundary.
        if (blank_i) begin
            state_d     = ST_OFF;
            idx_d       = '0;
            timer_d     = '0;
            frame_pulse = 1'b0;
        end

        if (frame_pulse) begin
            if (load_i) begin
                shadow_d = value_i;
            end else if (pend_flag_q) begin
                shadow_d = pending_q;
            end
            pend_flag_d = 1'b0;
        end else if (load_i) begin
            pending_d   = value_i;
            pend_flag_d = 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
        assign digit_sel[gi] = (idx_d == IW'(gi));
    end

    // Outputs are precomputed from the next state so the registered pins line up with it.
    always_comb begin
        an_d     = '1;
        nibble_d = nibble_q;
        if (state_d == ST_DRIVE) begin
            an_d     = ~(digit_sel & digit_en_i);
            nibble_d = shadow_d[{idx_d, 2'b00} +: 4];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_OFF;
            idx_q       <= '0;
            timer_q     <= '0;
            shadow_q    <= '0;
            pending_q   <= '0;
            pend_flag_q <= 1'b0;
            an_q        <= '1;
            nibble_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            pend_flag_q <= pend_flag_d;
            an_q        <= an_d;
            nibble_q    <= nibble_d;
        end
    end

    assign nibble_o       = nibble_q;
    assign an_o           = an_q;
    assign frame_o        = frame_pulse & ~rst_i;
    assign load_pending_o = pend_flag_q;

endmodule
